score_saver: RTL and testbench

- Downstream companion to the game timer: keeps the current game score and the session high score, both as two BCD digits.
- When the timer signals end of game, it compares the score against the high score, updates the high score if beaten, and asserts done_save back to the timer.
- It holds that state until the next go, then clears the score for a new game.
- Score and high-score digits feed the HEX display stage.

---
 rtl/score_saver_pkg.sv | 15 +
 rtl/score_saver_if.sv | 25 ++
 rtl/score_saver_bcd_add_sat.sv | 34 +++
 rtl/score_saver.sv | 98 +++++++++
 tb/tb_score_saver.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/score_saver_pkg.sv
// Shared types and constants for the score saver: FSM state encoding and the
// BCD limits used by the score adder and the high-score compare.
package score_pkg;

  typedef enum logic [1:0] {
    S_PLAY  = 2'd0,
    S_CMP   = 2'd1,
    S_WRITE = 2'd2,
    S_SAVED = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [7:0] SCORE_MAX     = 8'h99;

endpackage

// File: rtl/score_saver_if.sv
// Game-side signals of the score saver: inputs from the timer and the basket
// sensor, BCD score/high-score digits and status flags toward display and timer.
interface score_saver_if;

  logic       go;
  logic       timer_done;
  logic       basket;
  logic [3:0] score_one;
  logic [3:0] score_ten;
  logic [3:0] high_one;
  logic [3:0] high_ten;
  logic       new_record;
  logic       done_save;

  modport master (
    output go, timer_done, basket,
    input  score_one, score_ten, high_one, high_ten, new_record, done_save
  );

  modport slave (
    input  go, timer_done, basket,
    output score_one, score_ten, high_one, high_ten, new_record, done_save
  );

endinterface

// File: rtl/score_saver_bcd_add_sat.sv
// Two-digit BCD value plus a single-digit constant, clamped at 99.
// Purely combinational; the score register lives in the top module.
module bcd_add_sat
  import score_pkg::*;
#(
  parameter int unsigned ADD = 2
) (
  input  logic [3:0] in_ten,
  input  logic [3:0] in_one,
  output logic [3:0] out_ten,
  output logic [3:0] out_one
);

  logic [4:0] one_sum;
  logic [4:0] ten_sum;

  // Add to the ones digit, carry into tens on overflow past 9, clamp above 99
  always_comb begin
    one_sum = {1'b0, in_one} + 5'(ADD);
    ten_sum = {1'b0, in_ten};
    if (one_sum > {1'b0, BCD_MAX_DIGIT}) begin
      one_sum = one_sum - 5'd10;
      ten_sum = ten_sum + 5'd1;
    end
    if (ten_sum > {1'b0, BCD_MAX_DIGIT}) begin
      out_ten = SCORE_MAX[7:4];
      out_one = SCORE_MAX[3:0];
    end else begin
      out_ten = ten_sum[3:0];
      out_one = one_sum[3:0];
    end
  end

endmodule

// File: rtl/score_saver.sv
// Score saver: counts BCD score during play, and on the rising edge of the
// timer's done level compares against the session high score, stores a new
// record if beaten and reports done_save until the next go.
module score_saver
  import score_pkg::*;
#(
  parameter int unsigned BASKET_PTS = 2
) (
  input  logic         clk,
  input  logic         reset,
  score_saver_if.slave bus
);

  state_t     state_q, state_d;
  logic [7:0] score_q, score_d;
  logic [7:0] high_q, high_d;
  logic       new_record_q, new_record_d;
  logic       done_q, done_d;
  logic       done_rise;
  logic [3:0] sum_ten;
  logic [3:0] sum_one;

  bcd_add_sat #(
    .ADD (BASKET_PTS)
  ) u_add (
    .in_ten  (score_q[7:4]),
    .in_one  (score_q[3:0]),
    .out_ten (sum_ten),
    .out_one (sum_one)
  );

  assign done_rise = bus.timer_done & ~done_q;

  // Next-state logic: scoring in play, compare/store on game end, hold until go
  always_comb begin
    state_d      = state_q;
    score_d      = score_q;
    high_d       = high_q;
    new_record_d = new_record_q;
    done_d       = bus.timer_done;
    unique case (state_q)
      S_PLAY: begin
        if (bus.basket) begin
          score_d = {sum_ten, sum_one};
        end
        if (done_rise) begin
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        if (score_q > high_q) begin
          new_record_d = 1'b1;
          state_d      = S_WRITE;
        end else begin
          new_record_d = 1'b0;
          state_d      = S_SAVED;
        end
      end
      S_WRITE: begin
        high_d  = score_q;
        state_d = S_SAVED;
      end
      S_SAVED: begin
        if (bus.go) begin
          score_d      = 8'h00;
          new_record_d = 1'b0;
          state_d      = S_PLAY;
        end
      end
      default: state_d = S_PLAY;
    endcase
  end

  // State and data registers; reset also wipes the session high score
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_PLAY;
      score_q      <= 8'h00;
      high_q       <= 8'h00;
      new_record_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      high_q       <= high_d;
      new_record_q <= new_record_d;
      done_q       <= done_d;
    end
  end

  assign bus.score_ten  = score_q[7:4];
  assign bus.score_one  = score_q[3:0];
  assign bus.high_ten   = high_q[7:4];
  assign bus.high_one   = high_q[3:0];
  assign bus.new_record = new_record_q;
  assign bus.done_save  = (state_q == S_SAVED);

endmodule

// File: tb/tb_score_saver.sv
// Self-checking bench for score_saver: a numeric reference model produces
// expected output vectors that are queued as stimulus is applied and popped
// when the DUT outputs are sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_score_saver;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  int   m_score;
  int   m_high;
  bit   m_rec;
  bit   m_saved;

  logic [17:0] exp_q[$];

  score_saver_if bus ();

  score_saver #(
    .BASKET_PTS (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [17:0] expv();
    return {4'(m_score / 10), 4'(m_score % 10), 4'(m_high / 10), 4'(m_high % 10),
            m_rec, m_saved};
  endfunction

  function automatic logic [17:0] obsv();
    return {bus.score_ten, bus.score_one, bus.high_ten, bus.high_one,
            bus.new_record, bus.done_save};
  endfunction

  function automatic int sat_add(input int s);
    return (s + 2 > 99) ? 99 : s + 2;
  endfunction

  task automatic cycle(input logic b, input logic td, input logic g);
    bus.basket     = b;
    bus.timer_done = td;
    bus.go         = g;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [17:0] e, o;
    reset = 1'b1;
    bus.basket = 1'b0; bus.timer_done = 1'b0; bus.go = 1'b0;
    m_score = 0; m_high = 0; m_rec = 0; m_saved = 0;
    exp_q.push_back(expv());
    repeat (2) @(negedge clk);
    o = obsv(); e = exp_q.pop_front(); n_checks++;
    if (o !== e) begin n_fail++; $display("[TB] FAIL reset_hold: got %h required %h", o, e); end
    reset = 1'b0;
    exp_q.push_back(expv());
    cycle(0, 0, 0);
    o = obsv(); e = exp_q.pop_front(); n_checks++;
    if (o !== e) begin n_fail++; $display("[TB] FAIL reset_release: got %h required %h", o, e); end
  endtask

  task automatic test_basic_score();
    logic [17:0] e, o;
    for (int i = 0; i < 3; i++) begin
      m_score = sat_add(m_score);
      exp_q.push_back(expv());
      cycle(1, 0, 0);
      o = obsv(); e = exp_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("[TB] FAIL basic_basket%0d: got %h required %h", i, o, e); end
    end
  endtask

  task automatic test_record();
    logic [17:0] e, o;
    for (int i = 0; i < 2; i++) begin
      m_score = sat_add(m_score);
      exp_q.push_back(expv());
      cycle(1, 0, 0);
      o = obsv(); e = exp_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("[TB] FAIL rec_basket%0d: got %h required %h", i, o, e); end
    end
    exp_q.push_back(expv());
    cycle(0, 1, 0);
    o = obsv(); e = exp_q.pop_front(); n_checks++;
    if (o !== e) begin n_fail++; $display("[TB] FAIL rec_cmp: got %h required %h", o, e); end
    m_rec = 1;
    exp_q.push_back(expv());
    cycle(0, 1, 0);
    o = obsv(); e = exp_q.pop_front(); n_checks++;
    if (o !== e) begin n_fail++; $display("[TB] FAIL rec_write: got %h required %h", o, e); end
    m_high = m_score; m_saved = 1;
    exp_q.push_back(expv());
    cycle(0, 1, 0);
    o = obsv(); e = exp_q.pop_front(); n_checks++;
    if (o !== e) begin n_fail++; $display("[TB] FAIL rec_saved: got %h required %h", o, e); end
  endtask

  task automatic test_no_record();
    logic [17:0] e, o;
    m_score = 0; m_rec = 0; m_saved = 0;
    exp_q.push_back(expv());
    cycle(0, 1, 1);
    o = obsv(); e = exp_q.pop_front(); n_checks++;
    if (o !== e) begin n_fail++; $display("[TB] FAIL go_clear: got %h required %h", o, e); end
    for (int i = 0; i < 4; i++) begin
      m_score = sat_add(m_score);
      exp_q.push_back(expv());
      cycle(1, 1, 0);
      o = obsv(); e = exp_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("[TB] FAIL level_no_retrigger%0d: got %h required %h", i, o, e); end
    end
    exp_q.push_back(expv());
    cycle(0, 0, 0);
    o = obsv(); e = exp_q.pop_front(); n_checks++;
    if (o !== e) begin n_fail++; $display("[TB] FAIL norec_td_low: got %h required %h", o, e); end
    exp_q.push_back(expv());
    cycle(0, 1, 0);
    o = obsv(); e = exp_q.pop_front(); n_checks++;
    if (o !== e) begin n_fail++; $display("[TB] FAIL norec_cmp: got %h required %h", o, e); end
    m_saved = 1;
    exp_q.push_back(expv());
    cycle(0, 1, 0);
    o = obsv(); e = exp_q.pop_front(); n_checks++;
    if (o !== e) begin n_fail++; $display("[TB] FAIL norec_saved: got %h required %h", o, e); end
  endtask

  task automatic test_reset_write();
    logic [17:0] e, o;
    m_score = 0; m_rec = 0; m_saved = 0;
    exp_q.push_back(expv());
    cycle(0, 0, 1);
    o = obsv(); e = exp_q.pop_front(); n_checks++;
    if (o !== e) begin n_fail++; $display("[TB] FAIL rw_go: got %h required %h", o, e); end
    for (int i = 0; i < 6; i++) begin
      m_score = sat_add(m_score);
      exp_q.push_back(expv());
      cycle(1, 0, 0);
      o = obsv(); e = exp_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("[TB] FAIL rw_basket%0d: got %h required %h", i, o, e); end
    end
    exp_q.push_back(expv());
    cycle(0, 1, 0);
    o = obsv(); e = exp_q.pop_front(); n_checks++;
    if (o !== e) begin n_fail++; $display("[TB] FAIL rw_cmp: got %h required %h", o, e); end
    m_rec = 1;
    exp_q.push_back(expv());
    cycle(0, 1, 0);
    o = obsv(); e = exp_q.pop_front(); n_checks++;
    if (o !== e) begin n_fail++; $display("[TB] FAIL rw_write: got %h required %h", o, e); end
    bus.timer_done = 1'b0;
    #2 reset = 1'b1;
    m_score = 0; m_high = 0; m_rec = 0; m_saved = 0;
    exp_q.push_back(expv());
    #1;
    o = obsv(); e = exp_q.pop_front(); n_checks++;
    if (o !== e) begin n_fail++; $display("[TB] FAIL async_reset: got %h required %h", o, e); end
    @(negedge clk);
    reset = 1'b0;
    m_score = sat_add(m_score);
    exp_q.push_back(expv());
    cycle(1, 0, 0);
    o = obsv(); e = exp_q.pop_front(); n_checks++;
    if (o !== e) begin n_fail++; $display("[TB] FAIL post_reset_play: got %h required %h", o, e); end
  endtask

  task automatic test_saturate();
    logic [17:0] e, o;
    for (int i = 0; i < 60; i++) begin
      m_score = sat_add(m_score);
      exp_q.push_back(expv());
      cycle(1, 0, 0);
      o = obsv(); e = exp_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("[TB] FAIL sat_basket%0d: got %h required %h", i, o, e); end
    end
    exp_q.push_back(expv());
    cycle(0, 1, 0);
    o = obsv(); e = exp_q.pop_front(); n_checks++;
    if (o !== e) begin n_fail++; $display("[TB] FAIL sat_cmp: got %h required %h", o, e); end
    m_rec = 1;
    exp_q.push_back(expv());
    cycle(0, 1, 0);
    o = obsv(); e = exp_q.pop_front(); n_checks++;
    if (o !== e) begin n_fail++; $display("[TB] FAIL sat_write: got %h required %h", o, e); end
    m_high = m_score; m_saved = 1;
    exp_q.push_back(expv());
    cycle(0, 1, 0);
    o = obsv(); e = exp_q.pop_front(); n_checks++;
    if (o !== e) begin n_fail++; $display("[TB] FAIL sat_saved: got %h required %h", o, e); end
  endtask

  task automatic test_tie();
    logic [17:0] e, o;
    m_score = 0; m_rec = 0; m_saved = 0;
    exp_q.push_back(expv());
    cycle(0, 0, 1);
    o = obsv(); e = exp_q.pop_front(); n_checks++;
    if (o !== e) begin n_fail++; $display("[TB] FAIL tie_go: got %h required %h", o, e); end
    for (int i = 0; i < 50; i++) begin
      m_score = sat_add(m_score);
      exp_q.push_back(expv());
      cycle(1, 0, 0);
      o = obsv(); e = exp_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("[TB] FAIL tie_basket%0d: got %h required %h", i, o, e); end
    end
    exp_q.push_back(expv());
    cycle(0, 1, 0);
    o = obsv(); e = exp_q.pop_front(); n_checks++;
    if (o !== e) begin n_fail++; $display("[TB] FAIL tie_cmp: got %h required %h", o, e); end
    m_saved = 1;
    exp_q.push_back(expv());
    cycle(0, 1, 0);
    o = obsv(); e = exp_q.pop_front(); n_checks++;
    if (o !== e) begin n_fail++; $display("[TB] FAIL tie_saved: got %h required %h", o, e); end
  endtask

  task automatic test_back_to_back();
    logic [17:0] e, o;
    m_score = 0; m_rec = 0; m_saved = 0;
    exp_q.push_back(expv());
    cycle(0, 0, 1);
    o = obsv(); e = exp_q.pop_front(); n_checks++;
    if (o !== e) begin n_fail++; $display("[TB] FAIL b2b_go: got %h required %h", o, e); end
    for (int i = 0; i < 4; i++) begin
      m_score = sat_add(m_score);
      exp_q.push_back(expv());
      cycle(1, 0, 0);
      o = obsv(); e = exp_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("[TB] FAIL b2b_basket%0d: got %h required %h", i, o, e); end
    end
    m_score = sat_add(m_score);
    exp_q.push_back(expv());
    cycle(1, 1, 0);
    o = obsv(); e = exp_q.pop_front(); n_checks++;
    if (o !== e) begin n_fail++; $display("[TB] FAIL simul_basket_cmp: got %h required %h", o, e); end
    m_saved = 1;
    exp_q.push_back(expv());
    cycle(0, 1, 0);
    o = obsv(); e = exp_q.pop_front(); n_checks++;
    if (o !== e) begin n_fail++; $display("[TB] FAIL simul_saved: got %h required %h", o, e); end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(expv());
      cycle(1, 1, 0);
      o = obsv(); e = exp_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("[TB] FAIL saved_ignore_basket%0d: got %h required %h", i, o, e); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic_score();
    test_record();
    test_no_record();
    test_reset_write();
    test_saturate();
    test_tie();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
